// File: rtl/img_stream_loader_if.sv
// Image SRAM port bundle: the loader drives the write side (mst), the SRAM wrapper returns dout (slv).
interface img_sram_intf #(
    parameter int PIX_W = 8,
    parameter int DIM_W = 8
);
    logic             write_en;
    logic             sense_en;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic [PIX_W-1:0] din;
    logic [PIX_W-1:0] dout;

    modport mst (output write_en, sense_en, row, col, din, input dout);
    modport slv (input write_en, sense_en, row, col, din, output dout);
endinterface

// File: rtl/img_stream_loader.sv
// Raster-order pixel stream to image SRAM loader; pulses done when the nrows x ncols frame is committed.
// Optional build macro LOADER_LAST_CHECK_EN flags s_last/end-of-row disagreement in the sticky err bit.
module img_stream_loader #(
    parameter int PIX_W = 8,
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [DIM_W-1:0] nrows,
    input  logic [DIM_W-1:0] ncols,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    img_sram_intf.mst        sram_img
);
    localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0] DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [DIM_W-1:0] nrows_r, ncols_r, row_cnt_r, col_cnt_r;
    logic [DIM_W-1:0] nrows_nxt_s, ncols_nxt_s, row_cnt_nxt_s, col_cnt_nxt_s;
    logic             err_r, err_nxt_s;
    logic             s_ready_r, busy_r, done_r, we_r;
    logic [DIM_W-1:0] row_r, col_r;
    logic [PIX_W-1:0] din_r;
    logic             accept_s, last_col_s, last_row_s;
    logic             unused_dout_s;

    assign unused_dout_s = ^sram_img.dout;

    // Next-state, frame counters and sticky error.
    always_comb begin
        state_nxt_s   = state_r;
        nrows_nxt_s   = nrows_r;
        ncols_nxt_s   = ncols_r;
        row_cnt_nxt_s = row_cnt_r;
        col_cnt_nxt_s = col_cnt_r;
        err_nxt_s     = err_r;
        accept_s      = 1'b0;
        last_col_s    = (col_cnt_r == (ncols_r - DIM_ONE));
        last_row_s    = (row_cnt_r == (nrows_r - DIM_ONE));
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((nrows != DIM_ZERO) && (ncols != DIM_ZERO)) begin
                        nrows_nxt_s   = nrows;
                        ncols_nxt_s   = ncols;
                        row_cnt_nxt_s = DIM_ZERO;
                        col_cnt_nxt_s = DIM_ZERO;
                        err_nxt_s     = 1'b0;
                        state_nxt_s   = LOAD;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                accept_s = s_valid & s_ready_r;
                if (accept_s) begin
                    if (last_col_s) begin
                        col_cnt_nxt_s = DIM_ZERO;
                        if (last_row_s) begin
                            row_cnt_nxt_s = DIM_ZERO;
                            state_nxt_s   = FLUSH;
                        end else begin
                            row_cnt_nxt_s = row_cnt_r + DIM_ONE;
                        end
                    end else begin
                        col_cnt_nxt_s = col_cnt_r + DIM_ONE;
                    end
`ifdef LOADER_LAST_CHECK_EN
                    // A misplaced s_last only flags; addressing keeps following the counters.
                    if (s_last != last_col_s) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
`endif
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            FLUSH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

`ifndef LOADER_LAST_CHECK_EN
    logic unused_last_s;
    assign unused_last_s = s_last;
`endif

    // State, latched dimensions, counters and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            nrows_r   <= DIM_ZERO;
            ncols_r   <= DIM_ZERO;
            row_cnt_r <= DIM_ZERO;
            col_cnt_r <= DIM_ZERO;
            err_r     <= 1'b0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            nrows_r   <= nrows_nxt_s;
            ncols_r   <= ncols_nxt_s;
            row_cnt_r <= row_cnt_nxt_s;
            col_cnt_r <= col_cnt_nxt_s;
            err_r     <= err_nxt_s;
            s_ready_r <= (state_nxt_s == LOAD);
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_r == FLUSH);
        end
    end

    // SRAM write port: each accepted beat is written in the following cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_r  <= 1'b0;
            row_r <= DIM_ZERO;
            col_r <= DIM_ZERO;
            din_r <= {PIX_W{1'b0}};
        end else begin
            we_r <= accept_s;
            if (accept_s) begin
                row_r <= row_cnt_r;
                col_r <= col_cnt_r;
                din_r <= s_data;
            end
        end
    end

    assign s_ready           = s_ready_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign err               = err_r;
    assign sram_img.write_en = we_r;
    assign sram_img.sense_en = we_r;
    assign sram_img.row      = row_r;
    assign sram_img.col      = col_r;
    assign sram_img.din      = din_r;
endmodule
